// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter.
// Holds the CDB lane count, tag widths, FU requester ordering and the lane payload struct.
`ifndef CDB_WIDTH
`define CDB_WIDTH 4
`endif

package cdb_arbiter_pkg;

  localparam int unsigned NUM_REQ   = 6;
  localparam int unsigned CDB_WIDTH = `CDB_WIDTH;
  localparam int unsigned PR_WIDTH  = 7;
  localparam int unsigned AR_WIDTH  = 5;

  // Index of a requester, and a count of granted lanes (0..CDB_WIDTH)
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(CDB_WIDTH + 1);

  // Requester slot assignment; the position fixes the bit in fu_req_valid/fu_grant
  typedef enum logic [IDX_W-1:0] {
    FU_ALU0 = 3'd0,
    FU_ALU1 = 3'd1,
    FU_MULT = 3'd2,
    FU_LDST = 3'd3,
    FU_STD  = 3'd4,
    FU_BR   = 3'd5
  } fu_id_e;

  // One CDB lane payload
  typedef struct packed {
    logic                valid;
    logic [PR_WIDTH-1:0] pr_tag;
    logic [AR_WIDTH-1:0] ar_tag;
  } cdb_lane_t;

  // Next requester index, wrapping at NUM_REQ
  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin selector.
// Scans req starting at index 'start' (wrapping), grants the first CDB_WIDTH set bits.
// Ports:
//   req      - request vector, one bit per FU
//   start    - highest-priority index (must be < NUM_REQ)
//   grant    - one-hot-per-FU grant vector
//   lane_idx - FU index placed on each lane, in priority order
//   lane_vld - lane k carries a granted FU
module rr_pick4
  import cdb_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [IDX_W-1:0]                    start,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [CDB_WIDTH-1:0][IDX_W-1:0]     lane_idx,
  output logic [CDB_WIDTH-1:0]                lane_vld
);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // Walk the rotated order; the k-th hit lands on lane k
  always_comb begin
    grant    = '0;
    lane_idx = '0;
    lane_vld = '0;
    cnt      = '0;
    sum      = '0;
    idx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, start} + (IDX_W + 1)'(off);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (req[idx] && (cnt < CNT_W'(CDB_WIDTH))) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < CDB_WIDTH; k++) begin
          if (cnt == CNT_W'(k)) begin
            lane_idx[k] = idx;
            lane_vld[k] = 1'b1;
          end
        end
        cnt = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the CDB lanes among completing functional units.
// Grants up to CDB_WIDTH requesters per cycle in round-robin order and registers
// their PR/AR tags onto the CDB lanes one cycle later.
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   recover           - mispredict recovery: no grants, next broadcast squashed, pointer cleared
//   fu_req_valid      - per-FU completion request
//   fu_req_pr_tag     - packed PR tags, FU i at [i*PR_WIDTH +: PR_WIDTH]
//   fu_req_ar_tag     - packed AR tags, FU i at [i*AR_WIDTH +: AR_WIDTH]
//   fu_grant          - combinational grant, same cycle as the request
//   cdb_broadcast     - registered lane-valid bits
//   cdb_pr_tag0..3    - registered lane PR tags (0 on invalid lanes)
//   cdb_ar_tag0..3    - registered lane AR tags (0 on invalid lanes)
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         recover,
  input  logic [NUM_REQ-1:0]           fu_req_valid,
  input  logic [NUM_REQ*PR_WIDTH-1:0]  fu_req_pr_tag,
  input  logic [NUM_REQ*AR_WIDTH-1:0]  fu_req_ar_tag,
  output logic [NUM_REQ-1:0]           fu_grant,
  output logic [CDB_WIDTH-1:0]         cdb_broadcast,
  output logic [PR_WIDTH-1:0]          cdb_pr_tag0,
  output logic [PR_WIDTH-1:0]          cdb_pr_tag1,
  output logic [PR_WIDTH-1:0]          cdb_pr_tag2,
  output logic [PR_WIDTH-1:0]          cdb_pr_tag3,
  output logic [AR_WIDTH-1:0]          cdb_ar_tag0,
  output logic [AR_WIDTH-1:0]          cdb_ar_tag1,
  output logic [AR_WIDTH-1:0]          cdb_ar_tag2,
  output logic [AR_WIDTH-1:0]          cdb_ar_tag3
);

  logic [IDX_W-1:0]                rr_ptr;
  logic [IDX_W-1:0]                rr_ptr_d;
  logic [NUM_REQ-1:0]              pick_grant;
  logic [CDB_WIDTH-1:0][IDX_W-1:0] lane_idx;
  logic [CDB_WIDTH-1:0]            lane_vld;
  cdb_lane_t [CDB_WIDTH-1:0]       lane_q;
  cdb_lane_t [CDB_WIDTH-1:0]       lane_d;

  // Priority selection starting at rr_ptr
  rr_pick4 u_pick (
    .req      (fu_req_valid),
    .start    (rr_ptr),
    .grant    (pick_grant),
    .lane_idx (lane_idx),
    .lane_vld (lane_vld)
  );

  // Grants are suppressed during reset and recovery
  assign fu_grant = (reset && !recover) ? pick_grant : '0;

  // Lane payload mux: copy the selected FU's tags, zero for unused lanes
  always_comb begin
    lane_d = '0;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (lane_vld[k] && !recover) begin
        lane_d[k].valid = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (lane_idx[k] == IDX_W'(i)) begin
            lane_d[k].pr_tag = fu_req_pr_tag[i*PR_WIDTH +: PR_WIDTH];
            lane_d[k].ar_tag = fu_req_ar_tag[i*AR_WIDTH +: AR_WIDTH];
          end
        end
      end
    end
  end

  // Pointer moves past the last granted FU (highest used lane); holds when idle
  always_comb begin
    rr_ptr_d = rr_ptr;
    if (recover) begin
      rr_ptr_d = '0;
    end else begin
      for (int k = 0; k < CDB_WIDTH; k++) begin
        if (lane_vld[k]) begin
          rr_ptr_d = idx_inc(lane_idx[k]);
        end
      end
    end
  end

  // Lane registers and round-robin pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lane_q <= '0;
      rr_ptr <= '0;
    end else begin
      lane_q <= lane_d;
      rr_ptr <= rr_ptr_d;
    end
  end

  always_comb begin
    for (int k = 0; k < CDB_WIDTH; k++) begin
      cdb_broadcast[k] = lane_q[k].valid;
    end
  end

  assign cdb_pr_tag0 = lane_q[0].pr_tag;
  assign cdb_pr_tag1 = lane_q[1].pr_tag;
  assign cdb_pr_tag2 = lane_q[2].pr_tag;
  assign cdb_pr_tag3 = lane_q[3].pr_tag;
  assign cdb_ar_tag0 = lane_q[0].ar_tag;
  assign cdb_ar_tag1 = lane_q[1].ar_tag;
  assign cdb_ar_tag2 = lane_q[2].ar_tag;
  assign cdb_ar_tag3 = lane_q[3].ar_tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expected grants and lane contents.
module tb_cdb_arbiter;

  logic        clock;
  logic        reset;
  logic        recover;
  logic [5:0]  fu_req_valid;
  logic [41:0] fu_req_pr_tag;
  logic [29:0] fu_req_ar_tag;
  logic [5:0]  fu_grant;
  logic [3:0]  cdb_broadcast;
  logic [6:0]  cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
  logic [4:0]  cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .recover       (recover),
    .fu_req_valid  (fu_req_valid),
    .fu_req_pr_tag (fu_req_pr_tag),
    .fu_req_ar_tag (fu_req_ar_tag),
    .fu_grant      (fu_grant),
    .cdb_broadcast (cdb_broadcast),
    .cdb_pr_tag0   (cdb_pr_tag0),
    .cdb_pr_tag1   (cdb_pr_tag1),
    .cdb_pr_tag2   (cdb_pr_tag2),
    .cdb_pr_tag3   (cdb_pr_tag3),
    .cdb_ar_tag0   (cdb_ar_tag0),
    .cdb_ar_tag1   (cdb_ar_tag1),
    .cdb_ar_tag2   (cdb_ar_tag2),
    .cdb_ar_tag3   (cdb_ar_tag3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
    end
  endtask

  task automatic set_fu(input int i, input int pr, input int ar);
    fu_req_pr_tag[i*7 +: 7] = 7'(pr);
    fu_req_ar_tag[i*5 +: 5] = 5'(ar);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [5:0] exp);
    #1;
    check_eq({tag, ".grant"}, 32'(fu_grant), 32'(exp));
  endtask

  task automatic chk_cdb(input string tag, input logic [3:0] bc,
                         input int p0, input int p1, input int p2, input int p3,
                         input int a0, input int a1, input int a2, input int a3);
    check_eq({tag, ".bcast"}, 32'(cdb_broadcast), 32'(bc));
    check_eq({tag, ".pr0"}, 32'(cdb_pr_tag0), 32'(p0));
    check_eq({tag, ".pr1"}, 32'(cdb_pr_tag1), 32'(p1));
    check_eq({tag, ".pr2"}, 32'(cdb_pr_tag2), 32'(p2));
    check_eq({tag, ".pr3"}, 32'(cdb_pr_tag3), 32'(p3));
    check_eq({tag, ".ar0"}, 32'(cdb_ar_tag0), 32'(a0));
    check_eq({tag, ".ar1"}, 32'(cdb_ar_tag1), 32'(a1));
    check_eq({tag, ".ar2"}, 32'(cdb_ar_tag2), 32'(a2));
    check_eq({tag, ".ar3"}, 32'(cdb_ar_tag3), 32'(a3));
  endtask

  initial begin
    // Reset held with random requests present
    reset         = 1'b0;
    recover       = 1'b0;
    fu_req_valid  = 6'($urandom);
    fu_req_pr_tag = 42'({$urandom, $urandom});
    fu_req_ar_tag = 30'($urandom);
    #2;
    chk_gnt("rst_hold", 6'b000000);
    chk_cdb("rst_hold", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    fu_req_valid = 6'b111111;
    step();
    step();
    chk_gnt("rst_clk", 6'b000000);
    chk_cdb("rst_clk", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);

    // First grant after release: FU0 alone, rr_ptr 0 -> 1
    reset        = 1'b1;
    fu_req_valid = 6'b000001;
    set_fu(0, 32, 3);
    chk_gnt("first", 6'b000001);
    step();
    chk_cdb("first", 4'b0001, 32, 0, 0, 0, 3, 0, 0, 0);

    // FU1,FU2 from rr_ptr 1 -> rr_ptr 3
    fu_req_valid = 6'b000110;
    set_fu(1, 33, 4);
    set_fu(2, 34, 5);
    chk_gnt("two", 6'b000110);
    step();
    chk_cdb("two", 4'b0011, 33, 34, 0, 0, 4, 5, 0, 0);

    // Recovery with four requests: no grants, lanes cleared, rr_ptr 0
    recover      = 1'b1;
    fu_req_valid = 6'b011011;
    chk_gnt("recover", 6'b000000);
    step();
    chk_cdb("recover", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    recover = 1'b0;

    // Full contention from rr_ptr 0: FU0..FU3, rr_ptr -> 4
    fu_req_valid = 6'b111111;
    for (int i = 0; i < 6; i++) set_fu(i, 10 + i, i + 1);
    chk_gnt("full1", 6'b001111);
    step();
    chk_cdb("full1", 4'b1111, 10, 11, 12, 13, 1, 2, 3, 4);

    // FU0..FU3 re-request with new tags: grants FU4,FU5,FU0,FU1, rr_ptr -> 2
    for (int i = 0; i < 4; i++) set_fu(i, 20 + i, 11 + i);
    chk_gnt("full2", 6'b110011);
    step();
    chk_cdb("full2", 4'b1111, 14, 15, 20, 21, 5, 6, 11, 12);

    // FU2 alone moves rr_ptr 2 -> 3
    fu_req_valid = 6'b000100;
    set_fu(2, 60, 16);
    chk_gnt("ptr3", 6'b000100);
    step();
    chk_cdb("ptr3", 4'b0001, 60, 0, 0, 0, 16, 0, 0, 0);

    // Sparse from rr_ptr 3: FU5 then FU2 (wrap); rr_ptr stays 3
    fu_req_valid = 6'b100100;
    set_fu(5, 50, 7);
    set_fu(2, 52, 8);
    chk_gnt("sparse", 6'b100100);
    step();
    chk_cdb("sparse", 4'b0011, 50, 52, 0, 0, 7, 8, 0, 0);

    // rr_ptr is 3: FU3 ahead of FU0; rr_ptr -> 1
    fu_req_valid = 6'b001001;
    set_fu(0, 70, 17);
    set_fu(3, 73, 18);
    chk_gnt("ptr_chk", 6'b001001);
    step();
    chk_cdb("ptr_chk", 4'b0011, 73, 70, 0, 0, 18, 17, 0, 0);

    // FU4 alone: rr_ptr 1 -> 5
    fu_req_valid = 6'b010000;
    set_fu(4, 74, 19);
    chk_gnt("ptr5", 6'b010000);
    step();
    chk_cdb("ptr5", 4'b0001, 74, 0, 0, 0, 19, 0, 0, 0);

    // Hold rule: FU3 (pr 40/ar 9) loses first round from rr_ptr 5
    fu_req_valid = 6'b111111;
    for (int i = 0; i < 6; i++) set_fu(i, 80 + i, 20 + i);
    set_fu(3, 40, 9);
    chk_gnt("hold1", 6'b100111);
    step();
    chk_cdb("hold1", 4'b1111, 85, 80, 81, 82, 25, 20, 21, 22);

    // Only FU3,FU4 still pending, tags unchanged; rr_ptr 3
    fu_req_valid = 6'b011000;
    chk_gnt("hold2", 6'b011000);
    step();
    chk_cdb("hold2", 4'b0011, 40, 84, 0, 0, 9, 24, 0, 0);

    // Nothing pending: broadcast seen exactly once
    fu_req_valid = 6'b000000;
    chk_gnt("idle", 6'b000000);
    step();
    chk_cdb("idle", 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lanes valid, then async reset between edges
    fu_req_valid = 6'b000011;
    set_fu(0, 90, 26);
    set_fu(1, 91, 27);
    chk_gnt("pre_rst", 6'b000011);
    step();
    chk_cdb("pre_rst", 4'b0011, 90, 91, 0, 0, 26, 27, 0, 0);
    fu_req_valid = 6'b100001;
    set_fu(0, 100, 28);
    set_fu(5, 105, 29);
    reset = 1'b0;
    #1;
    check_eq("async_rst.bcast", 32'(cdb_broadcast), 32'(4'b0000));
    check_eq("async_rst.pr0", 32'(cdb_pr_tag0), 32'd0);
    check_eq("async_rst.grant", 32'(fu_grant), 32'd0);

    // After release rr_ptr is 0 again: FU0 ahead of FU5
    @(negedge clock);
    reset = 1'b1;
    chk_gnt("post_rst", 6'b100001);
    step();
    chk_cdb("post_rst", 4'b0011, 100, 105, 0, 0, 28, 29, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 4-lane common data bus between the completing functional units of the out-of-order core.
- Each cycle it picks up to CDB_WIDTH requesters in round-robin order and grants them.
- It registers their physical/architectural tags onto the CDB lanes consumed by the map table, RS and ROB.
- Requesters not granted hold their request; recovery squashes all pending and in-flight broadcasts.

Parameters:
- NUM_REQ, 6, number of completing functional-unit requesters.
- CDB_WIDTH, 4, number of CDB lanes (equals the `CDB_WIDTH macro).
- PR_WIDTH, 7, physical register tag width.
- AR_WIDTH, 5, architectural register tag width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- recover  in  1  branch-mispredict recovery; squash this cycle's grants and the next broadcast.
- fu_req_valid  in  NUM_REQ  per-FU completion request.
- fu_req_pr_tag  in  NUM_REQ*PR_WIDTH  packed destination PR tags; FU i occupies bits [i*PR_WIDTH +: PR_WIDTH].
- fu_req_ar_tag  in  NUM_REQ*AR_WIDTH  packed destination AR tags, same packing.
- fu_grant  out  NUM_REQ  combinational grant, same cycle as the request.
- cdb_broadcast  out  CDB_WIDTH  registered lane-valid bits.
- cdb_pr_tag0..cdb_pr_tag3  out  PR_WIDTH each  registered lane PR tags.
- cdb_ar_tag0..cdb_ar_tag3  out  AR_WIDTH each  registered lane AR tags.

Behaviour:
- Reset (reset==0, asynchronous):
  - cdb_broadcast=0, all cdb tags=0, rr_ptr=0.
  - fu_grant=0 while reset is asserted.
- Selection (combinational):
  - Rotate fu_req_valid so index rr_ptr is highest priority.
  - Take the first min(CDB_WIDTH, popcount) set bits in rotated order.
  - fu_grant is high for exactly those FUs.
  - fu_grant=0 for all FUs when recover=1.
- Lane packing: the k-th granted FU in priority order goes to lane k. Lanes 0..g-1 are used; lanes g..3 are invalid.
- Latency: a request granted at edge N is visible on the cdb_* outputs after edge N+1. Outputs are held exactly one cycle, then replaced by the next cycle's selection.
- Invalid lanes: cdb_broadcast bit=0 and that lane's tags are driven to 0.
- Handshake:
  - An FU keeps valid and tags stable until it sees fu_grant high in the same cycle.
  - An FU may deassert only after it is granted.
  - A grant consumes the request; the FU may present a new request the next cycle.
- rr_ptr update, only on cycles with g>0 and recover=0:
  - rr_ptr <= (index of the last granted FU + 1) mod NUM_REQ.
  - With g==0, rr_ptr holds.
  - Wrap-around: last grant at NUM_REQ-1 sets rr_ptr to 0.
- recover=1:
  - No grants this cycle.
  - Next cycle cdb_broadcast=0 and tags=0.
  - rr_ptr resets to 0.
  - Requests already registered but not yet broadcast are dropped; FUs also flush on recover, so there is no resend obligation.
- Saturation: with more than CDB_WIDTH requests, the excess stays ungranted. Round-robin guarantees each requester a grant within ceil(NUM_REQ/CDB_WIDTH)=2 cycles of continuous contention.
- Duplicate PR tags across requesters are a caller error and are not checked.
- Reset mid-operation: outputs clear immediately (asynchronous); the first grant after reset release follows from rr_ptr=0.

Decomposition:
- Shared package/defines hold:
  - `CDB_WIDTH, PR/AR tag widths.
  - FU index constants (ALU0, ALU1, MULT, LDST, BR, …) fixing requester order.
- One sub-module, rr_pick4: a pure combinational priority selector.
  - Inputs: NUM_REQ-bit request vector and a start pointer.
  - Outputs: grant vector plus up to 4 lane indices and lane-valid bits.
- The top level holds rr_ptr, the lane registers and recovery logic.

Test Plan:
- Reset sequence: reset=0 with random requests -> all cdb outputs 0, fu_grant=0. After release, req=6'b000001 with pr 32 / ar 3 -> grant[0]=1 same cycle; next cycle cdb_broadcast=4'b0001, cdb_pr_tag0=32, cdb_ar_tag0=3.
- Full contention, all 6 valid, rr_ptr=0:
  - Cycle 1: grants FUs 0-3; lanes carry FU0..FU3 tags next cycle; rr_ptr=4.
  - Cycle 2 (FUs 4,5 still valid, 0-3 re-requesting): grants 4,5,0,1 in lanes 0-3; rr_ptr=2 (wrap).
- Sparse requests: req=6'b100100 with rr_ptr=3 -> lane0=FU5, lane1=FU2, cdb_broadcast=4'b0011, lanes 2-3 tags 0, rr_ptr=3.
- Hold rule: FU3 ungranted for 1 cycle keeps tag pr 40 / ar 9 -> broadcast appears within 2 cycles with unchanged tags, exactly once.
- Recovery: recover=1 with 4 valid requests -> fu_grant=0, next cycle cdb_broadcast=0, rr_ptr=0. Following cycle with recover=0 grants from FU0.
- Mid-stream async reset: assert reset low between edges while lanes are valid -> cdb_broadcast drops to 0 immediately without waiting for a clock edge.
